conv_accumulator: RTL



---
 rtl/lenet_pkg.sv | 25 ++
 rtl/acc_saturate.sv | 42 ++++
 rtl/conv_accumulator.sv | 102 ++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_pkg
//  Description : Shared constants for the LeNet-5 convolution datapath.
//                Holds the word widths, the one-hot accumulator state codes
//                and the Q8.8 saturation limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package lenet_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int ACC_WIDTH       = 32;
    localparam int FRACTIONAL_BITS = 8;

    // One-hot state codes; LOAD_W is reserved and never entered
    localparam logic [3:0] IDLE        = 4'b0001;
    localparam logic [3:0] LOAD_W      = 4'b0010;
    localparam logic [3:0] CALCULATION = 4'b0100;
    localparam logic [3:0] DONE        = 4'b1000;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;

endpackage
`default_nettype wire

// File: rtl/acc_saturate.sv
`default_nettype none
// ============================================================================
//  Module      : acc_saturate
//  Description : Clamps a signed accumulator word to a signed DATA_WIDTH
//                result. With RELU_EN defined, negative results become 0.
//                Configuration macro: RELU_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_saturate #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0]  i_acc,
    output logic        [DATA_WIDTH-1:0] o_sat
);

    // Largest / smallest representable result, sign-extended to ACC_WIDTH
    localparam logic signed [ACC_WIDTH-1:0] c_max =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_min =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] w_clamped;

    // Clamp out-of-range sums, then optionally zero negative results
    always_comb begin
        if (i_acc > c_max) begin
            w_clamped = c_max[DATA_WIDTH-1:0];
        end else if (i_acc < c_min) begin
            w_clamped = c_min[DATA_WIDTH-1:0];
        end else begin
            w_clamped = i_acc[DATA_WIDTH-1:0];
        end
`ifdef RELU_EN
        o_sat = w_clamped[DATA_WIDTH-1] ? '0 : w_clamped;
`else
        o_sat = w_clamped;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/conv_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : conv_accumulator
//  Description : Sums a window of NUM_TERMS Q8.8 products onto a bias,
//                saturates and presents one result per window via
//                valid/ready. Configuration macro: RELU_EN (in acc_saturate).
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_accumulator #(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = lenet_pkg::ACC_WIDTH,
    parameter int NUM_TERMS  = 25,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bias_valid,
    input  logic [DATA_WIDTH-1:0] bias_in,
    output logic                  bias_ready,
    input  logic                  prod_valid,
    input  logic [DATA_WIDTH-1:0] prod_in,
    output logic                  prod_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy
);
    import lenet_pkg::*;

    localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(NUM_TERMS - 1);
    localparam int                   c_ext  = ACC_WIDTH - DATA_WIDTH;

    logic [3:0]            r_state;
    logic [3:0]            w_state_next;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic [DATA_WIDTH-1:0] w_sat;
    logic                  w_bias_hs;
    logic                  w_prod_hs;

    // Handshake qualifiers and running sum including the offered product
    assign w_bias_hs = bias_valid & bias_ready;
    assign w_prod_hs = prod_valid & prod_ready;
    assign w_sum     = r_acc + {{c_ext{prod_in[DATA_WIDTH-1]}}, prod_in};

    acc_saturate #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat (
        .i_acc (w_sum),
        .o_sat (w_sat)
    );

    // Status outputs depend on the state register only
    assign bias_ready = (r_state == IDLE);
    assign prod_ready = (r_state == CALCULATION);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign out_data   = r_out_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; unreachable codes recover to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:        if (bias_valid) w_state_next = CALCULATION;
            CALCULATION: if (prod_valid && (r_cnt == c_last)) w_state_next = DONE;
            DONE:        if (out_ready) w_state_next = IDLE;
            default:     w_state_next = IDLE;
        endcase
    end

    // Accumulator, term counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_out_data <= '0;
        end else if (w_bias_hs) begin
            r_acc <= {{c_ext{bias_in[DATA_WIDTH-1]}}, bias_in};
            r_cnt <= '0;
        end else if (w_prod_hs) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (r_cnt == c_last) begin
                r_out_data <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire
